// File: rtl/fb_writer.sv
// Framebuffer fill stage: writes a framed pixel stream or a solid clear colour into the display SRAM.
// Optional mid-frame SOF resynchronisation is enabled by defining SOF_RESYNC_EN.
module fb_writer #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  clear_req,
  input  logic [DATA_WIDTH-1:0] clear_color,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sof_error,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din
);

  typedef enum logic [1:0] {IDLE, STREAM, CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] ptr, ptr_next;
  logic [DATA_WIDTH-1:0] color, color_next;
  logic                  we_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] din_next;
  logic                  done_next;
  logic                  sof_err_next;
  logic                  busy_next;
  logic                  accept;

  // A pending clear blocks the stream while idle so it always wins the race
  assign s_ready = (state == STREAM) || ((state == IDLE) && !clear_req);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    color_next   = color;
    we_next      = 1'b0;
    addr_next    = '0;
    din_next     = '0;
    done_next    = 1'b0;
    sof_err_next = sof_error;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next   = CLEAR;
          ptr_next     = '0;
          color_next   = clear_color;
          sof_err_next = 1'b0;
        end else if (accept && s_sof) begin
          we_next   = 1'b1;
          addr_next = '0;
          din_next  = s_data;
          if (FRAME_PIXELS == 1) begin
            done_next = 1'b1;
            ptr_next  = '0;
          end else begin
            ptr_next   = ADDR_WIDTH'(1);
            state_next = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          we_next  = 1'b1;
          din_next = s_data;
`ifdef SOF_RESYNC_EN
          if (s_sof && (ptr != '0)) begin
            addr_next    = '0;
            ptr_next     = ADDR_WIDTH'(1);
            sof_err_next = 1'b1;
          end else
`endif
          begin
            addr_next = ptr;
            if (ptr == LAST_ADDR) begin
              done_next  = 1'b1;
              ptr_next   = '0;
              state_next = IDLE;
            end else begin
              ptr_next = ptr + ADDR_WIDTH'(1);
            end
          end
        end
      end
      CLEAR: begin
        we_next   = 1'b1;
        addr_next = ptr;
        din_next  = color;
        if (ptr == LAST_ADDR) begin
          done_next  = 1'b1;
          ptr_next   = '0;
          state_next = IDLE;
        end else begin
          ptr_next = ptr + ADDR_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // busy also covers the final write so it stays aligned with sram_we
  assign busy_next = (state_next != IDLE) || we_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      color      <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_din   <= '0;
      frame_done <= 1'b0;
      sof_error  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      color      <= color_next;
      sram_we    <= we_next;
      sram_addr  <= addr_next;
      sram_din   <= din_next;
      frame_done <= done_next;
      sof_error  <= sof_err_next;
      busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: a frame-level model predicts every SRAM write and its cycle.
// Expectations follow SOF_RESYNC_EN when the macro is defined for the build.
module tb_fb_writer;

  localparam int AW = 17;
  localparam int DW = 12;
  localparam int FP = 8;
`ifdef SOF_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_sof;
  logic          clear_req;
  logic [DW-1:0] clear_color;
  logic          busy;
  logic          frame_done;
  logic          sof_error;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;

  fb_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .clear_req(clear_req), .clear_color(clear_color),
    .busy(busy), .frame_done(frame_done), .sof_error(sof_error),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_STREAM, M_CLEAR} mode_t;
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } wr_t;

  wr_t   q[$];
  mode_t mode      = M_IDLE;
  int    pos       = 0;
  int    clear_end = 0;
  logic  sof_flag  = 1'b0;
  int    cyc       = 0;
  int    vectors   = 0;
  int    fails     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares registered outputs against the scoreboard on every falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_we", 32'(sram_we), 32'd0);
      checkOutput("rst_addr", 32'(sram_addr), 32'd0);
      checkOutput("rst_din", 32'(sram_din), 32'd0);
      checkOutput("rst_done", 32'(frame_done), 32'd0);
      checkOutput("rst_soferr", 32'(sof_error), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
    end else begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        wr_t e;
        e = q.pop_front();
        checkOutput("we", 32'(sram_we), 32'd1);
        checkOutput("addr", 32'(sram_addr), 32'(e.addr));
        checkOutput("din", 32'(sram_din), 32'(e.data));
        checkOutput("frame_done", 32'(frame_done), 32'(e.done));
        checkOutput("busy_wr", 32'(busy), 32'd1);
      end else begin
        checkOutput("no_we", 32'(sram_we), 32'd0);
        checkOutput("no_done", 32'(frame_done), 32'd0);
        checkOutput("busy", 32'(busy), 32'(mode != M_IDLE));
      end
      checkOutput("sof_error", 32'(sof_error), 32'(sof_flag));
    end
  end

  task automatic push(input int c, input int a, input logic [DW-1:0] d, input logic dn);
    wr_t e;
    e.cyc = c; e.addr = AW'(a); e.data = d; e.done = dn;
    q.push_back(e);
  endtask

  // One clock of stimulus; the model decides acceptance from its own notion of readiness
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic sof,
                               input logic clr, input logic [DW-1:0] col);
    logic exp_ready;
    @(negedge clk);
    #1;
    s_valid = v; s_data = d; s_sof = sof; clear_req = clr; clear_color = col;
    #1;
    exp_ready = (mode == M_STREAM) || (mode == M_IDLE && !clr);
    checkOutput("s_ready", 32'(s_ready), 32'(exp_ready));
    case (mode)
      M_CLEAR: if (cyc == clear_end) mode = M_IDLE;
      M_IDLE: begin
        if (clr) begin
          mode      = M_CLEAR;
          clear_end = cyc + FP;
          sof_flag  = 1'b0;
          for (int i = 0; i < FP; i++) push(cyc + 2 + i, i, col, i == FP - 1);
        end else if (v && sof) begin
          push(cyc + 1, 0, d, FP == 1);
          if (FP > 1) begin
            pos  = 1;
            mode = M_STREAM;
          end
        end
      end
      default: begin
        if (v) begin
          if (RESYNC && sof && pos != 0) begin
            push(cyc + 1, 0, d, 1'b0);
            pos      = 1;
            sof_flag = 1'b1;
          end else begin
            push(cyc + 1, pos, d, pos == FP - 1);
            if (pos == FP - 1) begin
              pos  = 0;
              mode = M_IDLE;
            end else begin
              pos++;
            end
          end
        end
      end
    endcase
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_sof = 1'b0; clear_req = 1'b0; clear_color = '0;
    q.delete();
    mode = M_IDLE; pos = 0; sof_flag = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_sof = 1'b0; clear_req = 1'b0; clear_color = '0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back frame
    for (int i = 0; i < FP; i++) applyStimulus(1'b1, DW'(12'h100 + i), i == 0, 1'b0, '0);
    idleCycles(3);

    // Frame with valid toggling every cycle
    for (int i = 0; i < FP; i++) begin
      applyStimulus(1'b1, DW'(12'h200 + i), i == 0, 1'b0, '0);
      applyStimulus(1'b0, DW'(12'h3FF), 1'b0, 1'b0, '0);
    end
    idleCycles(2);

    // Non-SOF beats in idle are dropped, then a real frame
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(12'h050 + i), 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 12'hABC, 1'b1, 1'b0, '0);
    for (int i = 1; i < FP; i++) applyStimulus(1'b1, DW'(12'h300 + i), 1'b0, 1'b0, '0);
    idleCycles(2);

    // Clear with colour changing after entry
    applyStimulus(1'b1, 12'h123, 1'b1, 1'b1, 12'hF0F);
    for (int i = 0; i < FP + 3; i++) applyStimulus(1'b1, 12'h456, 1'b0, 1'b0, 12'h000);

    // SOF after three beats of a frame, then run the frame out
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(12'h400 + i), i == 0, 1'b0, '0);
    applyStimulus(1'b1, 12'h4AA, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4 * FP && mode == M_STREAM; i++)
      applyStimulus(1'b1, DW'(12'h500 + i), 1'b0, 1'b0, '0);
    idleCycles(3);

    // Clear entry drops any sticky SOF error
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 12'h0A5);
    idleCycles(FP + 3);

    // Reset in the middle of a frame, then a clean frame
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(12'h600 + i), i == 0, 1'b0, '0);
    doReset(3);
    for (int i = 0; i < FP; i++) applyStimulus(1'b1, DW'(12'h700 + i), i == 0, 1'b0, '0);
    idleCycles(3);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 9) == 0,
                    $urandom_range(0, 59) == 0, DW'($urandom));
    end
    for (int i = 0; i < 40 && (q.size() > 0 || mode != M_IDLE); i++) idleCycles(1);
    checkOutput("drain", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
